// File: rtl/fifo_write_pkt_if.sv
// Command/FIFO-side bundle for the packet writer.
// master: the environment (command decoder, programming port, TX FIFO status).
// slave : the packet writer itself.
interface fifo_write_pkt_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int CMD_W  = 4,
  parameter int LEN_W  = 12
);
  // command decoder handshake
  logic              fs;
  logic [CMD_W-1:0]  data_cmd;
  logic              err;
  logic              fd;
  logic              abort;
  logic [2:0]        so;
  logic [LEN_W-1:0]  so_data_len;

  // payload memory programming
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // descriptor table programming
  logic              desc_we;
  logic [CMD_W-1:0]  desc_idx;
  logic [ADDR_W-1:0] desc_base;
  logic [LEN_W-1:0]  desc_len;

  // TX FIFO write port
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_txd;
  logic              fifo_txen;

  modport master (
    output fs, data_cmd, err,
    output mem_we, mem_addr, mem_data,
    output desc_we, desc_idx, desc_base, desc_len,
    output fifo_full,
    input  fd, abort, so, so_data_len,
    input  fifo_txd, fifo_txen
  );

  modport slave (
    input  fs, data_cmd, err,
    input  mem_we, mem_addr, mem_data,
    input  desc_we, desc_idx, desc_base, desc_len,
    input  fifo_full,
    output fd, abort, so, so_data_len,
    output fifo_txd, fifo_txen
  );
endinterface

// File: rtl/fifo_write_pkt.sv
// Programmable packet source: on fs, streams the byte range selected by
// descriptor[data_cmd] from payload memory into the TX FIFO, optionally
// followed by an XOR checksum byte, with backpressure and error abort.
module fifo_write_pkt #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 7,
  parameter int CMD_W   = 4,
  parameter int LEN_W   = 12,
  parameter int CSUM_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  fifo_write_pkt_if.slave bus
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int NUM_DESC  = 1 << CMD_W;
  localparam bit CSUM_ON   = (CSUM_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HEAD  = 3'd2,
    S_WORK  = 3'd3,
    S_CSUM  = 3'd4,
    S_LAST  = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  // payload memory (not reset) and descriptor table (reset to zero)
  logic [DATA_W-1:0] mem_q       [MEM_DEPTH];
  logic [ADDR_W-1:0] desc_base_q [NUM_DESC];
  logic [LEN_W-1:0]  desc_len_q  [NUM_DESC];

  logic [DATA_W-1:0] rd_data;
  logic              txen;
  logic [DATA_W-1:0] txd;
  logic              fd;
  logic              abort;
  logic              accept;
  logic              last_byte;
  logic              err_live;

  // Asynchronous read: a write to the address being read lands at the
  // edge, so the current cycle still sees the old byte.
  assign rd_data   = mem_q[rd_addr_q];
  assign accept    = txen;
  // Only meaningful in WORK, where len_q is known to be non-zero.
  assign last_byte = (count_q == (len_q - LEN_W'(1)));
  assign err_live  = bus.err && ((state_q == S_LOAD) || (state_q == S_HEAD) ||
                                 (state_q == S_WORK) || (state_q == S_CSUM));

  // Payload memory write port
  always_ff @(posedge clk) begin
    if (bus.mem_we) begin
      mem_q[bus.mem_addr] <= bus.mem_data;
    end
  end

  // One register pair per descriptor entry, each with its own write decode
  generate
    for (genvar gi = 0; gi < NUM_DESC; gi++) begin : g_desc
      logic [ADDR_W-1:0] entry_base_d;
      logic [LEN_W-1:0]  entry_len_d;

      // Update this entry when the programming port addresses it
      always_comb begin
        entry_base_d = desc_base_q[gi];
        entry_len_d  = desc_len_q[gi];
        if (bus.desc_we && (bus.desc_idx == CMD_W'(gi))) begin
          entry_base_d = bus.desc_base;
          entry_len_d  = bus.desc_len;
        end
      end

      // Entry register; a write coinciding with LOAD is seen by the next LOAD
      always_ff @(posedge clk) begin
        if (rst) begin
          desc_base_q[gi] <= '0;
          desc_len_q[gi]  <= '0;
        end else begin
          desc_base_q[gi] <= entry_base_d;
          desc_len_q[gi]  <= entry_len_d;
        end
      end
    end
  endgenerate

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      len_q     <= '0;
      count_q   <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
    end
  end

  // Next-state logic; err in an active state overrides the normal path
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.fs) state_d = S_LOAD;
      S_LOAD:  state_d = S_HEAD;
      S_HEAD: begin
        if (len_q == '0) state_d = CSUM_ON ? S_CSUM : S_LAST;
        else             state_d = S_WORK;
      end
      S_WORK:  if (accept && last_byte) state_d = CSUM_ON ? S_CSUM : S_LAST;
      S_CSUM:  if (accept) state_d = S_LAST;
      S_LAST:  if (!bus.fs) state_d = S_IDLE;
      S_ABORT: if (!bus.fs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (err_live) state_d = S_ABORT;
  end

  // Datapath: descriptor latch, per-packet clear, per-byte advance
  always_comb begin
    rd_addr_d = rd_addr_q;
    len_d     = len_q;
    count_d   = count_q;
    csum_d    = csum_q;
    case (state_q)
      S_LOAD: begin
        rd_addr_d = desc_base_q[bus.data_cmd];
        len_d     = desc_len_q[bus.data_cmd];
      end
      S_HEAD: begin
        count_d = '0;
        csum_d  = '0;
      end
      S_WORK: begin
        if (accept) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          count_d   = count_q + LEN_W'(1);
          csum_d    = csum_q ^ rd_data;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; txd forced to zero whenever txen is low
  always_comb begin
    txen  = 1'b0;
    txd   = '0;
    fd    = 1'b0;
    abort = 1'b0;
    case (state_q)
      S_WORK: begin
        txen = !bus.fifo_full;
        txd  = rd_data;
      end
      S_CSUM: begin
        txen = !bus.fifo_full;
        txd  = csum_q;
      end
      S_LAST:  fd    = 1'b1;
      S_ABORT: abort = 1'b1;
      default: ;
    endcase
    if (!txen) txd = '0;
  end

  assign bus.fifo_txen   = txen;
  assign bus.fifo_txd    = txd;
  assign bus.fd          = fd;
  assign bus.abort       = abort;
  assign bus.so          = state_q;
  assign bus.so_data_len = len_q;

endmodule

// File: tb/tb_fifo_write_pkt.sv
// Directed bench for fifo_write_pkt: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_fifo_write_pkt;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int CMD_W  = 4;
  localparam int LEN_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_write_pkt_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .LEN_W(LEN_W)) bus ();
  fifo_write_pkt_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .LEN_W(LEN_W)) bus0 ();

  fifo_write_pkt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .LEN_W(LEN_W), .CSUM_EN(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  fifo_write_pkt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .LEN_W(LEN_W), .CSUM_EN(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int errors = 0;

  task automatic init_inputs();
    bus.fs = 0; bus.data_cmd = '0; bus.err = 0; bus.fifo_full = 0;
    bus.mem_we = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.desc_we = 0; bus.desc_idx = '0; bus.desc_base = '0; bus.desc_len = '0;
    bus0.fs = 0; bus0.data_cmd = '0; bus0.err = 0; bus0.fifo_full = 0;
    bus0.mem_we = 0; bus0.mem_addr = '0; bus0.mem_data = '0;
    bus0.desc_we = 0; bus0.desc_idx = '0; bus0.desc_base = '0; bus0.desc_len = '0;
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.mem_we = 1; bus.mem_addr = a; bus.mem_data = d;
    @(negedge clk);
    bus.mem_we = 0;
  endtask

  task automatic write_desc(input logic [CMD_W-1:0] idx, input logic [ADDR_W-1:0] base,
                            input logic [LEN_W-1:0] len);
    @(negedge clk);
    bus.desc_we = 1; bus.desc_idx = idx; bus.desc_base = base; bus.desc_len = len;
    @(negedge clk);
    bus.desc_we = 0;
  endtask

  // Drop fs while in LAST/ABORT; returns one cycle after, when IDLE is expected
  task automatic release_fs();
    @(negedge clk);
    bus.fs = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.so !== 3'd0) begin errors++; $display("FAIL reset_so got %0d want 0", bus.so); end
    checks++; if (bus.fifo_txen !== 1'b0) begin errors++; $display("FAIL reset_txen got %0b want 0", bus.fifo_txen); end
    checks++; if (bus.fifo_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %02h want 00", bus.fifo_txd); end
    checks++; if (bus.fd !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL reset_fd_abort got fd=%0b abort=%0b want 0 0", bus.fd, bus.abort); end
    checks++; if (bus.so_data_len !== 12'd0) begin errors++; $display("FAIL reset_len got %0d want 0", bus.so_data_len); end
    checks++; if (bus0.so !== 3'd0 || bus0.fifo_txen !== 1'b0) begin errors++; $display("FAIL reset_dut0 got so=%0d txen=%0b want 0 0", bus0.so, bus0.fifo_txen); end
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int e_so [8];
    int e_en [8];
    int e_d  [8];
    e_so = '{1, 2, 3, 3, 3, 3, 4, 5};
    e_en = '{0, 0, 1, 1, 1, 1, 1, 0};
    e_d  = '{0, 0, 'h11, 'h22, 'h33, 'h44, 'h44, 0};
    write_mem(0, 8'h11); write_mem(1, 8'h22); write_mem(2, 8'h33); write_mem(3, 8'h44);
    write_desc(2, 0, 4);
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) bus.data_cmd = 4'd9;   // descriptor already latched in LOAD
      #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== e_d[i][7:0]) begin
        errors++;
        $display("FAIL basic_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i], e_d[i]);
      end
    end
    checks++; if (bus.fd !== 1'b1) begin errors++; $display("FAIL basic_fd got %0b want 1", bus.fd); end
    checks++; if (bus.so_data_len !== 12'd4) begin errors++; $display("FAIL basic_len got %0d want 4", bus.so_data_len); end
    @(negedge clk); #1;
    checks++; if (bus.so !== 3'd5) begin errors++; $display("FAIL basic_hold_last got %0d want 5", bus.so); end
    @(negedge clk); bus.fs = 0; #1;
    checks++; if (bus.fd !== 1'b1) begin errors++; $display("FAIL basic_fd_fslow got %0b want 1", bus.fd); end
    @(negedge clk); #1;
    checks++; if (bus.so !== 3'd0 || bus.fd !== 1'b0) begin errors++; $display("FAIL basic_idle got so=%0d fd=%0b want 0 0", bus.so, bus.fd); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    int e_so [10];
    int e_en [10];
    int e_d  [10];
    int full [10];
    full = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    e_so = '{1, 2, 3, 3, 3, 3, 3, 3, 4, 5};
    e_en = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 0};
    e_d  = '{0, 0, 'h11, 0, 0, 'h22, 'h33, 'h44, 'h44, 0};
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.fifo_full = full[i][0];
      #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== e_d[i][7:0]) begin
        errors++;
        $display("FAIL bp_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i], e_d[i]);
      end
    end
    bus.fifo_full = 0;
    checks++; if (bus.fd !== 1'b1) begin errors++; $display("FAIL bp_fd got %0b want 1", bus.fd); end
    release_fs();
    checks++; if (bus.so !== 3'd0) begin errors++; $display("FAIL bp_idle got %0d want 0", bus.so); end
    $display("test_backpressure done");
  endtask

  task automatic test_wrap();
    int e_so [8];
    int e_en [8];
    int e_d  [8];
    e_so = '{1, 2, 3, 3, 3, 3, 4, 5};
    e_en = '{0, 0, 1, 1, 1, 1, 1, 0};
    e_d  = '{0, 0, 'hA1, 'hA2, 'hA3, 'hA4, 'h04, 0};
    write_desc(5, 126, 4);
    write_mem(126, 8'hA1); write_mem(127, 8'hA2); write_mem(0, 8'hA3); write_mem(1, 8'hA4);
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== e_d[i][7:0]) begin
        errors++;
        $display("FAIL wrap_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i], e_d[i]);
      end
    end
    checks++; if (bus.so_data_len !== 12'd4) begin errors++; $display("FAIL wrap_len got %0d want 4", bus.so_data_len); end
    release_fs();
    checks++; if (bus.so !== 3'd0) begin errors++; $display("FAIL wrap_idle got %0d want 0", bus.so); end
    $display("test_wrap done");
  endtask

  task automatic test_len0();
    int e_so [4];
    int e_en [4];
    int z_so [3];
    e_so = '{1, 2, 4, 5};
    e_en = '{0, 0, 1, 0};
    z_so = '{1, 2, 5};
    write_desc(7, 3, 0);
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== 8'h00) begin
        errors++;
        $display("FAIL len0_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=00",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i]);
      end
    end
    checks++; if (bus.fd !== 1'b1 || bus.so_data_len !== 12'd0) begin errors++; $display("FAIL len0_fd got fd=%0b len=%0d want 1 0", bus.fd, bus.so_data_len); end
    release_fs();
    // checksum disabled: descriptor 7 is still at its reset value (len 0)
    @(negedge clk);
    bus0.fs = 1; bus0.data_cmd = 7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus0.so !== z_so[i][2:0] || bus0.fifo_txen !== 1'b0 || bus0.fd !== (i == 2)) begin
        errors++;
        $display("FAIL nocsum_cyc%0d got so=%0d txen=%0b fd=%0b want so=%0d txen=0 fd=%0b",
                 i, bus0.so, bus0.fifo_txen, bus0.fd, z_so[i], (i == 2));
      end
    end
    @(negedge clk); bus0.fs = 0;
    @(negedge clk); #1;
    checks++; if (bus0.so !== 3'd0) begin errors++; $display("FAIL nocsum_idle got %0d want 0", bus0.so); end
    $display("test_len0 done");
  endtask

  task automatic test_err();
    int e_so [7];
    int e_en [7];
    int e_d  [7];
    int e_ab [7];
    int errv [7];
    int b_so [8];
    int b_en [8];
    int b_d  [8];
    int nbytes;
    int fd_seen;
    errv = '{0, 0, 0, 1, 0, 0, 0};
    e_so = '{1, 2, 3, 3, 6, 6, 6};
    e_en = '{0, 0, 1, 1, 0, 0, 0};
    e_d  = '{0, 0, 'h11, 'h22, 0, 0, 0};
    e_ab = '{0, 0, 0, 0, 1, 1, 1};
    b_so = '{1, 2, 3, 3, 3, 3, 4, 5};
    b_en = '{0, 0, 1, 1, 1, 1, 1, 0};
    b_d  = '{0, 0, 'h11, 'h22, 'h33, 'h44, 'h44, 0};
    nbytes = 0;
    fd_seen = 0;
    write_mem(0, 8'h11); write_mem(1, 8'h22);
    // err in IDLE is ignored
    @(negedge clk); bus.err = 1;
    @(negedge clk); #1;
    checks++; if (bus.so !== 3'd0 || bus.abort !== 1'b0) begin errors++; $display("FAIL err_idle got so=%0d abort=%0b want 0 0", bus.so, bus.abort); end
    bus.err = 0;
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.err = errv[i][0];
      #1;
      if (bus.fifo_txen === 1'b1) nbytes++;
      if (bus.fd !== 1'b0) fd_seen++;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== e_d[i][7:0] || bus.abort !== e_ab[i][0]) begin
        errors++;
        $display("FAIL err_cyc%0d got so=%0d txen=%0b txd=%02h abort=%0b want so=%0d txen=%0b txd=%02h abort=%0b",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, bus.abort, e_so[i], e_en[i], e_d[i], e_ab[i]);
      end
    end
    checks++; if (nbytes !== 2) begin errors++; $display("FAIL err_nbytes got %0d want 2", nbytes); end
    checks++; if (fd_seen !== 0) begin errors++; $display("FAIL err_fd got %0d fd cycles want 0", fd_seen); end
    @(negedge clk); bus.fs = 0; #1;
    checks++; if (bus.so !== 3'd6) begin errors++; $display("FAIL err_abort_hold got %0d want 6", bus.so); end
    @(negedge clk); #1;
    checks++; if (bus.so !== 3'd0 || bus.abort !== 1'b0) begin errors++; $display("FAIL err_idle_after got so=%0d abort=%0b want 0 0", bus.so, bus.abort); end
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.so !== b_so[i][2:0] || bus.fifo_txen !== b_en[i][0] || bus.fifo_txd !== b_d[i][7:0]) begin
        errors++;
        $display("FAIL err_retry_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, b_so[i], b_en[i], b_d[i]);
      end
    end
    release_fs();
    $display("test_err done");
  endtask

  task automatic test_reset_mid();
    int e_so [4];
    int e_en [4];
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.so !== 3'd3 || bus.fifo_txd !== 8'h11) begin errors++; $display("FAIL rmid_work got so=%0d txd=%02h want 3 11", bus.so, bus.fifo_txd); end
    @(negedge clk);
    rst = 1; bus.fs = 0;
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (bus.so !== 3'd0 || bus.fifo_txen !== 1'b0 || bus.fifo_txd !== 8'h00) begin errors++; $display("FAIL rmid_state got so=%0d txen=%0b txd=%02h want 0 0 00", bus.so, bus.fifo_txen, bus.fifo_txd); end
    checks++; if (bus.so_data_len !== 12'd0 || bus.fd !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL rmid_outs got len=%0d fd=%0b abort=%0b want 0 0 0", bus.so_data_len, bus.fd, bus.abort); end
    e_so = '{1, 2, 4, 5};
    e_en = '{0, 0, 1, 0};
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== 8'h00) begin
        errors++;
        $display("FAIL rmid_len0_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=00",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i]);
      end
    end
    checks++; if (bus.so_data_len !== 12'd0 || bus.fd !== 1'b1) begin errors++; $display("FAIL rmid_len0_end got len=%0d fd=%0b want 0 1", bus.so_data_len, bus.fd); end
    release_fs();
    $display("test_reset_mid done");
  endtask

  task automatic test_same_cycle();
    int e_so [8];
    int e_en [8];
    int e_d  [8];
    int s_so [5];
    int s_en [5];
    int s_d  [5];
    e_so = '{1, 2, 3, 3, 3, 3, 4, 5};
    e_en = '{0, 0, 1, 1, 1, 1, 1, 0};
    e_d  = '{0, 0, 'h11, 'h22, 'h33, 'h44, 'h44, 0};
    s_so = '{1, 2, 3, 4, 5};
    s_en = '{0, 0, 1, 1, 0};
    s_d  = '{0, 0, 'h55, 'h55, 0};
    write_desc(2, 0, 4);
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      // rewrite descriptor 2 during LOAD, and mem[0] while it is presented
      bus.desc_we = (i == 0); bus.desc_idx = 2; bus.desc_base = 0; bus.desc_len = 1;
      bus.mem_we = (i == 2); bus.mem_addr = 0; bus.mem_data = 8'h55;
      #1;
      checks++;
      if (bus.so !== e_so[i][2:0] || bus.fifo_txen !== e_en[i][0] || bus.fifo_txd !== e_d[i][7:0]) begin
        errors++;
        $display("FAIL same_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, e_so[i], e_en[i], e_d[i]);
      end
    end
    checks++; if (bus.so_data_len !== 12'd4) begin errors++; $display("FAIL same_len_old got %0d want 4", bus.so_data_len); end
    release_fs();
    @(negedge clk);
    bus.fs = 1; bus.data_cmd = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.so !== s_so[i][2:0] || bus.fifo_txen !== s_en[i][0] || bus.fifo_txd !== s_d[i][7:0]) begin
        errors++;
        $display("FAIL same_new_cyc%0d got so=%0d txen=%0b txd=%02h want so=%0d txen=%0b txd=%02h",
                 i, bus.so, bus.fifo_txen, bus.fifo_txd, s_so[i], s_en[i], s_d[i]);
      end
    end
    checks++; if (bus.so_data_len !== 12'd1) begin errors++; $display("FAIL same_len_new got %0d want 1", bus.so_data_len); end
    release_fs();
    $display("test_same_cycle done");
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len0();
    test_err();
    test_reset_mid();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_write_pkt.md
Name: fifo_write_pkt

Overview:
Parametrised packet source that streams a command-selected byte sequence into the downstream TX FIFO.
- Payload memory and per-command descriptor table (base, length) are runtime-programmable.
- Supports FIFO backpressure, an optional trailing XOR checksum byte, and error abort.
- Sits between the command decoder (fs/data_cmd) and the TX FIFO write port, using the same fs/fd handshake as the existing fixed-table writer.

Parameters:
DATA_W, 8, byte width of payload and fifo_txd
ADDR_W, 7, payload memory address width; depth = 2**ADDR_W
CMD_W, 4, command width; descriptor table has 2**CMD_W entries
LEN_W, 12, packet length width
CSUM_EN, 1, 1 = append XOR checksum byte after payload

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
fs  in  1  frame start request, level, held high until fd seen
data_cmd  in  CMD_W  descriptor select, sampled in LOAD
err  in  1  abort request
fd  out  1  frame done, high in LAST
abort  out  1  high in ABORT
so  out  3  current state code
so_data_len  out  LEN_W  latched length of current/last packet
mem_we  in  1  payload memory write strobe
mem_addr  in  ADDR_W  payload write address
mem_data  in  DATA_W  payload write data
desc_we  in  1  descriptor write strobe
desc_idx  in  CMD_W  descriptor index
desc_base  in  ADDR_W  descriptor start address
desc_len  in  LEN_W  descriptor payload length
fifo_full  in  1  downstream backpressure
fifo_txd  out  DATA_W  byte to FIFO
fifo_txen  out  1  FIFO write enable

Behaviour:
- States and codes (so): IDLE=0, LOAD=1, HEAD=2, WORK=3, CSUM=4, LAST=5, ABORT=6. Unused code goes to IDLE.
- Reset (sync, rst high at an edge) applies to:
  - state: IDLE
  - so_data_len, byte count, checksum: 0
  - all descriptors: base 0, len 0
  - payload memory: not reset
  - resulting outputs: fifo_txen 0, fifo_txd 0, fd 0, abort 0, so 0
- Reset mid-packet returns to IDLE on that edge; no further txen.
- Transitions:
  - IDLE -> LOAD when fs = 1.
  - LOAD: latch descriptor[data_cmd] into rd_addr and so_data_len; go to HEAD.
  - HEAD: clear count and checksum.
    - len = 0 -> CSUM if CSUM_EN, else LAST.
    - otherwise -> WORK.
  - WORK: a byte is accepted when fifo_full = 0.
    - fifo_txen = 1 and fifo_txd = mem[rd_addr].
    - On acceptance: rd_addr+1 (wraps modulo 2**ADDR_W), count+1, csum ^= byte.
    - When the accepted byte has count = len-1: go to CSUM if CSUM_EN, else LAST.
  - CSUM: fifo_txen = !fifo_full, fifo_txd = csum; go to LAST on acceptance.
  - LAST: fd = 1; go to IDLE when fs = 0. fs still high means stay; no retrigger without fs low.
  - err = 1 in LOAD/HEAD/WORK/CSUM -> ABORT next edge; the byte in that cycle is still written if accepted. err is ignored in IDLE/LAST/ABORT.
  - ABORT: abort = 1, fifo_txen 0; go to IDLE when fs = 0.
- Output rules:
  - fifo_txen and fifo_txd are combinational from state, fifo_full, mem, csum.
  - fifo_txd = 0 whenever fifo_txen = 0.
  - fifo_full high: fifo_txen 0, pointer/count/csum held.
- Latency: fs rising sampled at edge N -> first byte presented in the cycle after edge N+2.
- Memory write to the address being read in the same cycle: read returns old data; new data is visible the next cycle.
- Descriptor write in the same cycle as LOAD: LOAD uses the old entry.
- Length and address arithmetic:
  - len up to 2**LEN_W-1.
  - len > 2**ADDR_W re-reads wrapped addresses.
  - The count never wraps, since it is bounded by len.

Test Plan:
- Program mem[0..3] = 11,22,33,44 and desc[2] = {base 0, len 4}; fs = 1 with data_cmd = 2 -> txen bytes 11,22,33,44,44 (checksum 0x44) on 5 consecutive cycles starting 3 cycles after fs sampled; fd = 1 and so_data_len = 4; IDLE one cycle after fs drops.
- Same packet with fifo_full high 2 cycles while 22 is presented -> txen low 2 cycles, 22 held, identical byte sequence and checksum 0x44.
- desc[5] = {base 126, len 4}, mem[126,127,0,1] = A1,A2,A3,A4 -> bytes A1,A2,A3,A4, checksum 0x04 (wrap verified).
- desc[7] len 0 -> single checksum byte 0x00, then fd; with CSUM_EN = 0 -> no txen, fd 3 cycles after fs sampled.
- err pulsed after 2nd WORK byte of the len 4 packet -> exactly 2 bytes written, abort = 1, fd never high; after fs low -> IDLE; next fs gives the full correct packet.
- rst asserted mid-WORK -> next edge so = 0, txen 0, so_data_len 0, descriptors cleared; fs then yields len 0 behaviour.
